// File: rtl/gray_ptr_sync_pkg.sv
// Shared types and helpers for the Gray pointer synchronizer.
package parammod_gray_pkg;

  typedef enum logic {
    TRACK   = 1'b0,
    SUSPECT = 1'b1
  } gsync_state_t;

  localparam int POP_MAX   = 32;
  localparam int POP_CNT_W = 6;

  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + POP_CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_gray_bin.sv
// Gray-to-binary converter: each binary bit is the XOR of the Gray bits at and above it.
module gray_bin #(
  parameter int DATA = 4
) (
  input  logic [DATA-1:0] gray,
  output logic [DATA-1:0] bin
);

  // Reduction over the right-shifted code keeps only bits DATA-1..i.
  always_comb begin
    bin = '0;
    for (int i = 0; i < DATA; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_ptr_sync.sv
// Synchronizes a foreign Gray code into clk, screens illegal multi-bit steps,
// and publishes the last accepted code in Gray and binary.
module gray_ptr_sync
  import parammod_gray_pkg::*;
#(
  parameter int DATA  = 4,
  parameter int STAGE = 2,
  parameter bit CHK   = 1'b1
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic [DATA-1:0] in_gray,
  input  logic            clr,
  output logic [DATA-1:0] out_gray,
  output logic [DATA-1:0] out_bin,
  output logic            upd,
  output logic            err
);

  logic [DATA-1:0]      sync_r [STAGE];
  logic [DATA-1:0]      gray_r;
  logic [DATA-1:0]      cand_r;
  gsync_state_t         state_r;
  logic                 upd_r;
  logic                 err_r;
  logic [DATA-1:0]      s_s;
  logic [DATA-1:0]      diff_s;
  logic [POP_CNT_W-1:0] n_s;
  gsync_state_t         eval_state_s;

  // Plain flop chain; nothing may sit between the stages.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < STAGE; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= in_gray;
      for (int i = 1; i < STAGE; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign s_s          = sync_r[STAGE-1];
  assign diff_s       = s_s ^ gray_r;
  assign n_s          = popcount(POP_MAX'(diff_s));
  assign eval_state_s = clr ? TRACK : state_r;

  // Acceptance FSM; clr drops back to TRACK rules but a fresh multi-bit hit still flags.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r <= TRACK;
      gray_r  <= '0;
      cand_r  <= '0;
      upd_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      upd_r <= 1'b0;
      if (clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
      case (eval_state_s)
        TRACK: begin
          state_r <= TRACK;
          if (n_s == 6'd1) begin
            gray_r <= s_s;
            upd_r  <= 1'b1;
          end else if ((n_s > 6'd1) && (CHK == 1'b1)) begin
            cand_r  <= s_s;
            err_r   <= 1'b1;
            state_r <= SUSPECT;
          end else if (n_s > 6'd1) begin
            gray_r <= s_s;
            upd_r  <= 1'b1;
          end else begin
            gray_r <= gray_r;
          end
        end
        SUSPECT: begin
          if (s_s == cand_r) begin
            gray_r  <= s_s;
            upd_r   <= 1'b1;
            state_r <= TRACK;
          end else if (n_s == 6'd1) begin
            gray_r  <= s_s;
            upd_r   <= 1'b1;
            state_r <= TRACK;
          end else if (s_s == gray_r) begin
            state_r <= TRACK;
          end else begin
            cand_r  <= s_s;
            state_r <= SUSPECT;
          end
        end
        default: begin
          state_r <= TRACK;
        end
      endcase
    end
  end

  gray_bin #(.DATA(DATA)) u_gray_bin (
    .gray (gray_r),
    .bin  (out_bin)
  );

  assign out_gray = gray_r;
  assign upd      = upd_r;
  assign err      = err_r;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: one CHK=1 instance and one CHK=0 instance.
module tb_gray_ptr_sync;

  logic       clk;
  logic       reset_a, clr_a, upd_a, err_a;
  logic [3:0] in_a, out_gray_a, out_bin_a;
  logic       reset_b, clr_b, upd_b, err_b;
  logic [3:0] in_b, out_gray_b, out_bin_b;
  int         tests_run;
  int         tests_failed;

  gray_ptr_sync #(.DATA(4), .STAGE(2), .CHK(1'b1)) dut_a (
    .clk(clk), .reset_(reset_a), .in_gray(in_a), .clr(clr_a),
    .out_gray(out_gray_a), .out_bin(out_bin_a), .upd(upd_a), .err(err_a)
  );

  gray_ptr_sync #(.DATA(4), .STAGE(2), .CHK(1'b0)) dut_b (
    .clk(clk), .reset_(reset_b), .in_gray(in_b), .clr(clr_b),
    .out_gray(out_gray_b), .out_bin(out_bin_b), .upd(upd_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    in_a = 4'b1010; in_b = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_gray_a !== 4'b0000 || out_bin_a !== 4'd0 || upd_a !== 1'b0 || err_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: gray=%b bin=%0d upd=%b err=%b, want 0000/0/0/0",
                 i, out_gray_a, out_bin_a, upd_a, err_a);
      end
    end
    in_a = 4'b0000;
    @(negedge clk);
    reset_a = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (out_gray_a !== 4'b0000 || err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: gray=%b err=%b, want 0000/0", out_gray_a, err_a);
    end
  endtask

  task automatic test_single_step();
    in_a = 4'b0001;
    repeat (2) @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_early_upd: upd=%b, want 0", upd_a);
    end
    @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b1 || out_bin_a !== 4'd1 || out_gray_a !== 4'b0001) begin
      tests_failed++;
      $display("FAIL step_edge3: upd=%b gray=%b bin=%0d, want 1/0001/1", upd_a, out_gray_a, out_bin_a);
    end
    @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_pulse_width: upd=%b, want 0", upd_a);
    end
    in_a = 4'b0011;
    repeat (3) @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b1 || out_bin_a !== 4'd2 || err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_second: upd=%b bin=%0d err=%b, want 1/2/0", upd_a, out_bin_a, err_a);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [13];
    seq = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101,
            4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    for (int i = 0; i < 13; i++) begin
      in_a = seq[i];
      repeat (4) @(negedge clk);
      tests_run++;
      if (out_bin_a !== 4'(i + 3) || err_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL count_up gray=%b: bin=%0d err=%b, want %0d/0", seq[i], out_bin_a, err_a, i + 3);
      end
    end
    in_a = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b1 || out_bin_a !== 4'd0 || err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap: upd=%b bin=%0d err=%b, want 1/0/0", upd_a, out_bin_a, err_a);
    end
    @(negedge clk);
  endtask

  task automatic test_multi_bit();
    in_a = 4'b0110;
    repeat (3) @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b0 || err_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL jump_edge3: upd=%b err=%b, want 0/1", upd_a, err_a);
    end
    @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b1 || out_bin_a !== 4'd4 || out_gray_a !== 4'b0110) begin
      tests_failed++;
      $display("FAIL jump_edge4: upd=%b gray=%b bin=%0d, want 1/0110/4", upd_a, out_gray_a, out_bin_a);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] path [3];
    path = '{4'b0010, 4'b0011, 4'b0001};
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_first: err=%b, want 0", err_a);
    end
    for (int i = 0; i < 3; i++) begin
      in_a = path[i];
      repeat (4) @(negedge clk);
    end
    tests_run++;
    if (out_bin_a !== 4'd1 || err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_setup: bin=%0d err=%b, want 1/0", out_bin_a, err_a);
    end
    in_a = 4'b0111;
    @(negedge clk);
    in_a = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (upd_a !== 1'b0 || out_bin_a !== 4'd1) begin
        tests_failed++;
        $display("FAIL glitch_reject cyc%0d: upd=%b bin=%0d, want 0/1", i, upd_a, out_bin_a);
      end
    end
    tests_run++;
    if (err_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_err: err=%b, want 1", err_a);
    end
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_clr: err=%b, want 0", err_a);
    end
    in_a = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b1 || out_bin_a !== 4'd0) begin
      tests_failed++;
      $display("FAIL after_glitch_step: upd=%b bin=%0d, want 1/0", upd_a, out_bin_a);
    end
    @(negedge clk);
  endtask

  task automatic test_clr_wins();
    in_a = 4'b0110;
    repeat (2) @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    tests_run++;
    if (err_a !== 1'b1 || upd_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_vs_jump: err=%b upd=%b, want 1/0", err_a, upd_a);
    end
    @(negedge clk);
    tests_run++;
    if (upd_a !== 1'b1 || out_bin_a !== 4'd4) begin
      tests_failed++;
      $display("FAIL clr_vs_jump_accept: upd=%b bin=%0d, want 1/4", upd_a, out_bin_a);
    end
  endtask

  task automatic test_nochk_and_async_reset();
    in_b = 4'b0000;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    in_b = 4'b0110;
    repeat (2) @(negedge clk);
    tests_run++;
    if (upd_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL nochk_early: upd=%b, want 0", upd_b);
    end
    @(negedge clk);
    tests_run++;
    if (upd_b !== 1'b1 || out_bin_b !== 4'd4 || err_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL nochk_jump: upd=%b bin=%0d err=%b, want 1/4/0", upd_b, out_bin_b, err_b);
    end
    #2;
    reset_b = 1'b0;
    #1;
    tests_run++;
    if (out_gray_b !== 4'b0000 || out_bin_b !== 4'd0 || upd_b !== 1'b0 || err_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: gray=%b bin=%0d upd=%b err=%b, want 0000/0/0/0",
               out_gray_b, out_bin_b, upd_b, err_b);
    end
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (upd_b !== 1'b1 || out_bin_b !== 4'd4) begin
      tests_failed++;
      $display("FAIL resync: upd=%b bin=%0d, want 1/4", upd_b, out_bin_b);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_step();
    test_wrap();
    test_multi_bit();
    test_glitch();
    test_clr_wins();
    test_nochk_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
